// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: two write ports, two read ports, scoreboard controls.
// Parameters must match the DATA_W/ADDR_W of the attached regfile_mp.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              we0;
    logic [ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0] wdata0;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic [ADDR_W-1:0] raddr0;
    logic [DATA_W-1:0] rdata0;
    logic              rbusy0;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              rbusy1;
    logic              alloc_en;
    logic [ADDR_W-1:0] alloc_addr;
    logic              flush;
    logic              wconf;

    // Producer side: writeback / decode logic drives the register file.
    modport master (
        output we0, waddr0, wdata0,
        output we1, waddr1, wdata1,
        output raddr0, raddr1,
        output alloc_en, alloc_addr, flush,
        input  rdata0, rbusy0, rdata1, rbusy1, wconf
    );

    // Register file side.
    modport slave (
        input  we0, waddr0, wdata0,
        input  we1, waddr1, wdata1,
        input  raddr0, raddr1,
        input  alloc_en, alloc_addr, flush,
        output rdata0, rbusy0, rdata1, rbusy1, wconf
    );
endinterface

// File: rtl/regfile_mp.sv
// Two-write / two-read integer register file with per-register pending scoreboard.
// Optional feature macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_REGS = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       GP_IDX   = 28,
    parameter logic [DATA_W-1:0] GP_INIT  = DATA_W'(32'h00001800),
    parameter int unsigned       SP_IDX   = 29,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(32'h00002ffc)
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  rf
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic                r_wconf;

    logic [NUM_REGS-1:0] w_pend_nxt;
    logic                w_wr0;
    logic                w_wr1;
    logic [DATA_W-1:0]   w_rdata0;
    logic [DATA_W-1:0]   w_rdata1;
    logic                w_rbusy0;
    logic                w_rbusy1;

    // Writes to register 0 are dropped everywhere by qualifying the enables here.
    assign w_wr0 = rf.we0 && (rf.waddr0 != '0);
    assign w_wr1 = rf.we1 && (rf.waddr1 != '0);

    // Register array; port 1 (late return) wins a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i == GP_IDX) begin
                    r_regs[i] <= GP_INIT;
                end else if (i == SP_IDX) begin
                    r_regs[i] <= SP_INIT;
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (w_wr1 && (rf.waddr1 == ADDR_W'(i))) begin
                    r_regs[i] <= rf.wdata1;
                end else if (w_wr0 && (rf.waddr0 == ADDR_W'(i))) begin
                    r_regs[i] <= rf.wdata0;
                end
            end
        end
    end

    // Scoreboard next state: flush beats everything, a new allocation beats a retiring write.
    always_comb begin
        w_pend_nxt = r_pend;
        if (rf.flush) begin
            w_pend_nxt = '0;
        end else begin
            if (w_wr0) begin
                w_pend_nxt[rf.waddr0] = 1'b0;
            end
            if (w_wr1) begin
                w_pend_nxt[rf.waddr1] = 1'b0;
            end
            if (rf.alloc_en && (rf.alloc_addr != '0)) begin
                w_pend_nxt[rf.alloc_addr] = 1'b1;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend  <= '0;
            r_wconf <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_wconf <= w_wr0 && w_wr1 && (rf.waddr0 == rf.waddr1);
        end
    end

    // Read port A.
    always_comb begin
        w_rdata0 = (rf.raddr0 == '0) ? '0 : r_regs[rf.raddr0];
        w_rbusy0 = r_pend[rf.raddr0];
`ifdef RF_BYPASS_EN
        if (rf.raddr0 != '0) begin
            if (w_wr1 && (rf.waddr1 == rf.raddr0)) begin
                w_rdata0 = rf.wdata1;
                w_rbusy0 = 1'b0;
            end else if (w_wr0 && (rf.waddr0 == rf.raddr0)) begin
                w_rdata0 = rf.wdata0;
                w_rbusy0 = 1'b0;
            end
        end
`endif
    end

    // Read port B.
    always_comb begin
        w_rdata1 = (rf.raddr1 == '0) ? '0 : r_regs[rf.raddr1];
        w_rbusy1 = r_pend[rf.raddr1];
`ifdef RF_BYPASS_EN
        if (rf.raddr1 != '0) begin
            if (w_wr1 && (rf.waddr1 == rf.raddr1)) begin
                w_rdata1 = rf.wdata1;
                w_rbusy1 = 1'b0;
            end else if (w_wr0 && (rf.waddr0 == rf.raddr1)) begin
                w_rdata1 = rf.wdata0;
                w_rbusy1 = 1'b0;
            end
        end
`endif
    end

    assign rf.rdata0 = w_rdata0;
    assign rf.rbusy0 = w_rbusy0;
    assign rf.rdata1 = w_rdata1;
    assign rf.rbusy1 = w_rbusy1;
    assign rf.wconf  = r_wconf;

endmodule
